// File: rtl/arb31_pkg.sv
// arb31_pkg: select codes, widths and grant/select helpers shared by arb31x32.
package arb31_pkg;

  localparam int unsigned OPW = 32;
  localparam int unsigned SW  = 2;
  localparam int unsigned BCW = 4;

  localparam logic [SW-1:0] SEL_A = 2'b00;
  localparam logic [SW-1:0] SEL_B = 2'b01;
  localparam logic [SW-1:0] SEL_C = 2'b10;

  // select code to one-hot requester mask
  function automatic logic [2:0] sel2oh(input logic [SW-1:0] sel);
    logic [2:0] oh;
    case (sel)
      SEL_A:   oh = 3'b001;
      SEL_B:   oh = 3'b010;
      SEL_C:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // one-hot grant to select code
  function automatic logic [SW-1:0] oh2sel(input logic [2:0] oh);
    logic [SW-1:0] sel;
    if (oh[2])      sel = SEL_C;
    else if (oh[1]) sel = SEL_B;
    else            sel = SEL_A;
    return sel;
  endfunction

endpackage

// File: rtl/mux31x32.sv
// mux31x32: shared 32-bit 3:1 operand mux; the unused code 11 yields zero.
module mux31x32
  import arb31_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [OPW-1:0] c,
  input  logic [SW-1:0]  s,
  output logic [OPW-1:0] y
);

  // select one operand
  always_comb begin
    y = '0;
    case (s)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick3.sv
// rr_pick3: combinational next-grantee for three requesters.
// ARB31X32_FIXED_PRIO_EN selects fixed priority a > b > c instead of
// round-robin with burst hold.
module rr_pick3
  import arb31_pkg::*;
#(
  parameter int unsigned BURST = 1
) (
  input  logic [2:0]     req,
  input  logic [SW-1:0]  last,
  input  logic [BCW-1:0] burst_cnt,
  input  logic           accept_en,
  output logic [2:0]     gnt
);

`ifdef ARB31X32_FIXED_PRIO_EN

  logic unused_rr;
  assign unused_rr = ^{last, burst_cnt};

  // fixed priority a > b > c
  always_comb begin
    gnt = 3'b000;
    if (accept_en) begin
      if (req[0])      gnt = 3'b001;
      else if (req[1]) gnt = 3'b010;
      else if (req[2]) gnt = 3'b100;
    end
  end

`else

  logic [SW-1:0] p1;
  logic [SW-1:0] p2;
  logic [2:0]    last_oh;
  logic [2:0]    others;
  logic          hold_ok;

  // round-robin with burst hold; burst_cnt==0 means nobody holds yet (post reset)
  always_comb begin
    gnt     = 3'b000;
    last_oh = sel2oh(last);
    others  = req & ~last_oh;
    hold_ok = (burst_cnt != '0) && (burst_cnt < BCW'(BURST));
    case (last)
      SEL_A:   begin p1 = SEL_B; p2 = SEL_C; end
      SEL_B:   begin p1 = SEL_C; p2 = SEL_A; end
      default: begin p1 = SEL_A; p2 = SEL_B; end
    endcase
    if (accept_en && (req != 3'b000)) begin
      if (((req & last_oh) != 3'b000) && (hold_ok || (others == 3'b000)))
        gnt = last_oh;
      else if ((req & sel2oh(p1)) != 3'b000)
        gnt = sel2oh(p1);
      else
        gnt = sel2oh(p2);
    end
  end

`endif

endmodule

// File: rtl/arb31x32.sv
// arb31x32: three-requester arbiter driving mux31x32 into a valid/ready output
// register. Define ARB31X32_FIXED_PRIO_EN for fixed priority a > b > c.
module arb31x32
  import arb31_pkg::*;
#(
  parameter int unsigned BURST = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     req,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [OPW-1:0] c,
  output logic [2:0]     gnt,
  output logic [SW-1:0]  s,
  output logic [OPW-1:0] dataout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_src
);

  logic [SW-1:0]  last_q;
  logic [BCW-1:0] burst_cnt_q;
  logic [SW-1:0]  s_q;
  logic [OPW-1:0] mux_y;
  logic           accept_en;
  logic           grant;
  logic [SW-1:0]  gnt_sel;

  // room for a word when empty or draining this cycle; never grant in reset
  assign accept_en = (!out_valid || out_ready) && !reset;

  rr_pick3 #(.BURST(BURST)) u_pick (
    .req       (req),
    .last      (last_q),
    .burst_cnt (burst_cnt_q),
    .accept_en (accept_en),
    .gnt       (gnt)
  );

  // select follows the grant, otherwise holds the last one used
  always_comb begin
    grant   = |gnt;
    gnt_sel = oh2sel(gnt);
    s       = grant ? gnt_sel : s_q;
  end

  mux31x32 u_mux (
    .a (a),
    .b (b),
    .c (c),
    .s (s),
    .y (mux_y)
  );

  // output register, arbitration pointer and burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout     <= '0;
      out_valid   <= 1'b0;
      out_src     <= SEL_A;
      s_q         <= SEL_A;
      last_q      <= SEL_C;
      burst_cnt_q <= '0;
    end else if (grant) begin
      dataout   <= mux_y;
      out_valid <= 1'b1;
      out_src   <= gnt_sel;
      s_q       <= gnt_sel;
      last_q    <= gnt_sel;
      if (gnt_sel == last_q)
        burst_cnt_q <= (burst_cnt_q < BCW'(BURST)) ? burst_cnt_q + BCW'(1) : burst_cnt_q;
      else
        burst_cnt_q <= BCW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/arb31x32.md
# arb31x32

Three-requester arbiter and sequencer for the shared 32-bit 3:1 operand mux `mux31x32`. Each cycle it picks one of three 32-bit sources `a`, `b` or `c` and drives the mux select. It captures the mux output in a single output register with a valid/ready handshake. It sits between the operand sources and a downstream arithmetic unit, so three producers can share one operand bus fairly.

## Interface
- `BURST`, default 1: maximum consecutive grants to one requester while another requester is waiting. Legal range 1–15.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 3: request vector; bit 0 = a, bit 1 = b, bit 2 = c.
- `a`, `b`, `c` in 32 each: source operands, routed to the `mux31x32` instance.
- `gnt` out 3: one-hot grant; combinational in the cycle of acceptance.
- `s` out 2: mux select; 00 = a, 01 = b, 10 = c. Never 11.
- `dataout` out 32: registered mux output.
- `out_valid` out 1: `dataout` holds an unconsumed word.
- `out_ready` in 1: downstream accepts `dataout`.
- `out_src` out 2: select code of the source captured in `dataout`.

## Operation
- Requester i's word is accepted in a cycle when `gnt[i]`=1. Requester i must hold its word stable while `req[i]`=1 and `gnt[i]`=0.
- Accept is enabled when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 (simultaneous drain and fill gives full throughput).
- When accept is enabled and `req` is nonzero, exactly one `gnt` bit is set.
- `gnt` is 0 whenever accept is disabled or `req` is 0.
- Round-robin policy:
  - A pointer `last` (0–2) records the most recent grantee.
  - Search order starts at `last`+1 mod 3 and wraps (c → a).
- Burst policy:
  - If `req[last]`=1 and `burst_cnt` < `BURST`, `last` keeps the grant.
  - If no other requester is active, `last` keeps the grant without limit.
  - Otherwise round-robin applies.
- `burst_cnt` rules:
  - Resets to 1 on a grant to a new requester.
  - Increments on a repeat grant, saturating at `BURST`.
- `s` follows the grant, so `dataout`/`out_src` load the selected source.
- When no grant is issued, `s` holds its previous value.
- `last` and `burst_cnt` update only on a grant.
- Output register:
  - Loads when there is a grant.
  - Clears `out_valid` on `out_ready` with no grant.
  - Otherwise holds.
- Starvation bound with `BURST`=1: a waiting requester is granted within 2 transfers.

## Timing
- Latency: word selected in cycle N appears on `dataout` with `out_valid`=1 in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1.
- Backpressure with `out_ready`=0 and `out_valid`=1:
  - `gnt`=0.
  - `dataout` and `out_src` remain stable.
  - Requesters stall.
- Values after reset:
  - `out_valid`=0, `dataout`=0, `out_src`=00, `s`=00, `gnt`=000.
  - `last`=2, so a is searched first.
  - `burst_cnt`=0.
- Reset mid-transfer: a pending `dataout` is discarded and no grant is issued in the reset cycle.
- Dropped request: `req` may drop at any time without a grant. That requester is skipped and no state changes.

## Configuration
- `ARB31X32_FIXED_PRIO_EN` defined:
  - Fixed priority a > b > c.
  - `last`, `burst_cnt` and `BURST` are unused.
  - Starvation is permitted.
- Undefined: round-robin with burst policy as above.
- Handshake, latency and reset behaviour are identical in both modes.

## Structure
- Shared package `arb31_pkg` holds:
  - Select constants `SEL_A`=2'b00, `SEL_B`=2'b01, `SEL_C`=2'b10.
  - Width constant `OPW`=32.
  - `burst_cnt` width.
- One sub-module, `rr_pick3`: a combinational next-grantee function taking `req`, `last`, `burst_cnt` and accept-enable.
- The arbiter instantiates `mux31x32` directly for the datapath.

## Test plan
- Reset, then `req`=001 with a=0x0000_0011 and `out_ready`=1:
  - `gnt`=001 and `s`=00 in cycle 1.
  - `dataout`=0x0000_0011, `out_src`=00, `out_valid`=1 in cycle 2.
- `req`=111 held, `BURST`=1, `out_ready`=1 for 6 cycles: grant order a, b, c, a, b, c.
- `req`=111, `BURST`=3, a/b/c held: grant order a, a, a, b, b, b, c.
- `out_ready`=0 after the first capture with `req`=010:
  - `gnt`=000 while stalled; `dataout` holds.
  - `out_ready`=1 → b is granted the same cycle as the drain, with no bubble.
- `reset` asserted while `out_valid`=1 and `req`=100: next cycle `out_valid`=0 and `gnt`=000; after release, c is granted first.
- With `ARB31X32_FIXED_PRIO_EN` and `req`=111 for 4 cycles: a is granted every cycle and c is never granted.
